// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: shared definitions for the multi-cycle ALU.
//   alu_op_t    - 4-bit opcode; encodings 9..15 are undefined ops
//   alu_state_t - control FSM states
package alu_mc_pkg;

  typedef enum logic [3:0] {
    aluADD = 4'd0,
    aluSUB = 4'd1,
    aluSL  = 4'd2,
    aluSR  = 4'd3,
    aluXOR = 4'd4,
    aluAND = 4'd5,
    aluBE  = 4'd6,
    aluBNE = 4'd7,
    aluMUL = 4'd8
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    MUL   = 2'd2,
    DONE  = 2'd3
  } alu_state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: radix-2 shift-and-add multiplier, one multiplier bit per clock.
//   clk, rst_n  clock / async active-low reset
//   i_start     load operands and begin (WIDTH iterations follow)
//   i_a, i_b    multiplicand / multiplier
//   o_done      high during the last iteration clock
//   o_prod      accumulator value after the current iteration (valid with o_done)
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_prod
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplr;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic [2*WIDTH-1:0] w_acc_nxt;

  assign w_acc_nxt = r_acc + (r_mplr[0] ? r_mcand : '0);
  // The product is handed out combinationally on the final iteration so the
  // caller can register it on the same edge it leaves its MUL state.
  assign o_done = r_busy && (r_cnt == CW'(1));
  assign o_prod = w_acc_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_mcand <= '0;
      r_mplr  <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else if (i_start) begin
      r_acc   <= '0;
      r_mcand <= {{WIDTH{1'b0}}, i_a};
      r_mplr  <= i_b;
      r_cnt   <= CW'(WIDTH);
      r_busy  <= 1'b1;
    end else if (r_busy) begin
      r_acc   <= w_acc_nxt;
      r_mcand <= {r_mcand[2*WIDTH-2:0], 1'b0};
      r_mplr  <= {1'b0, r_mplr[WIDTH-1:1]};
      r_cnt   <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshake.
//   clk, rst_n           clock / async active-low reset
//   in_valid, in_ready   operand handshake (in_ready = IDLE)
//   op, in_a, in_b       opcode and unsigned operands, captured on accept
//   out_valid, out_ready result handshake (out_valid = DONE)
//   rslt, rslt_hi        result; rslt_hi is the MUL high half, else 0
//   z, c                 compare flag (BE/BNE) / carry-borrow (ADD/SUB)
//
// state | meaning
// IDLE  | waiting for an operand handshake
// SHIFT | shifting working register one bit per clock
// MUL   | multiplier sub-module iterating
// DONE  | result valid, held until out_ready
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  alu_op_t          op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rslt,
  output logic [WIDTH-1:0] rslt_hi,
  output logic             z,
  output logic             c
);

  localparam logic [WIDTH-1:0] LP_WVAL = WIDTH'(WIDTH);

  alu_state_t         r_state, w_state_nxt;
  alu_op_t            r_op;
  logic [WIDTH-1:0]   r_work;
  logic [SHW-1:0]     r_cnt;
  logic [WIDTH-1:0]   r_rslt, r_rslt_hi;
  logic               r_z, r_c;

  logic               w_accept;
  logic               w_shift_iter;
  logic               w_mul_start;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_shift_nxt;
  logic [WIDTH-1:0]   w_rslt;
  logic               w_z, w_c;

  assign w_accept     = in_valid && (r_state == IDLE);
  assign w_shift_iter = ((op == aluSL) || (op == aluSR)) &&
                        (in_b != '0) && (in_b < LP_WVAL);
  assign w_mul_start  = w_accept && (op == aluMUL);
  assign w_shift_nxt  = (r_op == aluSL) ? {r_work[WIDTH-2:0], 1'b0}
                                        : {1'b0, r_work[WIDTH-1:1]};

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_mul_start),
    .i_a     (in_a),
    .i_b     (in_b),
    .o_done  (w_mul_done),
    .o_prod  (w_prod)
  );

  // Results for ops that finish on the accept edge. Shifts only land here
  // with a zero amount (pass-through) or an out-of-range amount (zero).
  always_comb begin
    w_rslt = '0;
    w_z    = 1'b0;
    w_c    = 1'b0;
    case (op)
      aluADD:        {w_c, w_rslt} = {1'b0, in_a} + {1'b0, in_b};
      aluSUB: begin
        w_rslt = in_a - in_b;
        w_c    = (in_a < in_b);
      end
      aluSL, aluSR:  w_rslt = (in_b == '0) ? in_a : '0;
      aluXOR:        w_rslt = in_a ^ in_b;
      aluAND:        w_rslt = in_a & in_b;
      aluBE:         w_z    = (in_a == in_b);
      aluBNE:        w_z    = (in_a != in_b);
      aluMUL:        w_rslt = '0;
      default:       w_rslt = '1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (op == aluMUL)  w_state_nxt = MUL;
          else if (w_shift_iter) w_state_nxt = SHIFT;
          else               w_state_nxt = DONE;
        end
      end
      SHIFT:   if (r_cnt == SHW'(1)) w_state_nxt = DONE;
      MUL:     if (w_mul_done)       w_state_nxt = DONE;
      DONE:    if (out_ready)        w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op      <= aluADD;
      r_work    <= '0;
      r_cnt     <= '0;
      r_rslt    <= '0;
      r_rslt_hi <= '0;
      r_z       <= 1'b0;
      r_c       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op   <= op;
            r_work <= in_a;
            r_cnt  <= in_b[SHW-1:0];
            if (!w_shift_iter && (op != aluMUL)) begin
              r_rslt    <= w_rslt;
              r_rslt_hi <= '0;
              r_z       <= w_z;
              r_c       <= w_c;
            end
          end
        end
        SHIFT: begin
          r_work <= w_shift_nxt;
          r_cnt  <= r_cnt - SHW'(1);
          if (r_cnt == SHW'(1)) begin
            r_rslt    <= w_shift_nxt;
            r_rslt_hi <= '0;
            r_z       <= 1'b0;
            r_c       <= 1'b0;
          end
        end
        MUL: begin
          if (w_mul_done) begin
            {r_rslt_hi, r_rslt} <= w_prod;
            r_z <= 1'b0;
            r_c <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign rslt      = r_rslt;
  assign rslt_hi   = r_rslt_hi;
  assign z         = r_z;
  assign c         = r_c;

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;
  import alu_mc_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  alu_op_t      op;
  logic [W-1:0] in_a, in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] rslt, rslt_hi;
  logic         z, c;

  int n_chk = 0;
  int n_err = 0;

  alu_mc #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rslt      (rslt),
    .rslt_hi   (rslt_hi),
    .z         (z),
    .c         (c)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: arithmetic on plain integers, latency from the op rules.
  task automatic ref_model(input logic [3:0] opv, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] r, output logic [W-1:0] hi,
                           output logic ez, output logic ec, output int lat);
    int ai, bi, p;
    ai = int'(a); bi = int'(b);
    r = '0; hi = '0; ez = 1'b0; ec = 1'b0; lat = 1;
    case (opv)
      4'd0: begin p = ai + bi; r = W'(p); ec = (p > 255); end
      4'd1: begin r = W'(ai - bi); ec = (ai < bi); end
      4'd2: begin
        r = (bi >= W) ? '0 : W'(ai << bi);
        if (bi > 0 && bi < W) lat = 1 + bi;
      end
      4'd3: begin
        r = (bi >= W) ? '0 : W'(ai >> bi);
        if (bi > 0 && bi < W) lat = 1 + bi;
      end
      4'd4: r = a ^ b;
      4'd5: r = a & b;
      4'd6: ez = (ai == bi);
      4'd7: ez = (ai != bi);
      4'd8: begin p = ai * bi; r = W'(p); hi = W'(p / 256); lat = W + 1; end
      default: r = '1;
    endcase
  endtask

  task automatic run_op(input string tag, input logic [3:0] opv,
                        input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    logic [W-1:0] er, eh, r0, h0;
    logic ez, ec, z0, c0;
    int el, lat;
    ref_model(opv, a, b, er, eh, ez, ec, el);
    @(negedge clk);
    chk({tag, ":in_ready_pre"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    op        = alu_op_t'(opv);
    in_a      = a;
    in_b      = b;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    op       = alu_op_t'(4'($urandom));
    in_a     = W'($urandom);
    in_b     = W'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ":latency"}, 32'(lat), 32'(el));
    chk({tag, ":rslt"}, 32'(rslt), 32'(er));
    chk({tag, ":rslt_hi"}, 32'(rslt_hi), 32'(eh));
    chk({tag, ":z"}, 32'(z), 32'(ez));
    chk({tag, ":c"}, 32'(c), 32'(ec));
    chk({tag, ":in_ready_busy"}, 32'(in_ready), 32'd0);
    r0 = rslt; h0 = rslt_hi; z0 = z; c0 = c;
    repeat (hold) @(negedge clk);
    if (hold > 0)
      chk({tag, ":held"}, 32'({rslt, rslt_hi, z, c, out_valid, in_ready}),
          32'({r0, h0, z0, c0, 1'b1, 1'b0}));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ":in_ready_after"}, 32'(in_ready), 32'd1);
    chk({tag, ":out_valid_after"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int seen;
    logic [3:0] ropv;
    logic [W-1:0] ra, rb;
    rst_n = 1'b0; in_valid = 1'b0; op = aluADD; in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst:state", 32'({out_valid, in_ready, rslt, rslt_hi, z, c}),
        32'({1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0}));
    rst_n = 1'b1;

    run_op("add_carry", 4'd0, 8'hF0, 8'h20, 0);
    run_op("sub_borrow", 4'd1, 8'h03, 8'h05, 0);
    run_op("sl3", 4'd2, 8'h01, 8'd3, 0);
    run_op("sr9", 4'd3, 8'h80, 8'd9, 0);
    run_op("sl0", 4'd2, 8'hA5, 8'd0, 0);
    run_op("sr7", 4'd3, 8'h80, 8'd7, 1);
    run_op("mul_13x11", 4'd8, 8'd13, 8'd11, 0);
    run_op("mul_ffxff", 4'd8, 8'hFF, 8'hFF, 0);
    run_op("be_eq", 4'd6, 8'd5, 8'd5, 0);
    run_op("bne_eq", 4'd7, 8'd5, 8'd5, 0);
    run_op("bne_ne", 4'd7, 8'd5, 8'd6, 0);
    run_op("undef_f", 4'hF, 8'h12, 8'h34, 0);
    run_op("add_bp", 4'd0, 8'h33, 8'h44, 3);
    run_op("xor_after_bp", 4'd4, 8'h5A, 8'hFF, 0);

    for (int i = 0; i < 60; i++) begin
      ropv = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      ra = W'($urandom);
      rb = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 10)) : W'($urandom);
      run_op("rand", ropv, ra, rb, $urandom_range(0, 3));
    end

    // asynchronous reset in the middle of a multiply
    run_op("add_pre_rst", 4'd0, 8'hF0, 8'h20, 0);
    @(negedge clk);
    in_valid = 1'b1; op = aluMUL; in_a = 8'd7; in_b = 8'd9;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mul:out_valid", 32'(out_valid), 32'd0);
    chk("rst_mul:outs", 32'({rslt, rslt_hi, z, c}), 32'd0);
    chk("rst_mul:in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("rst_mul:no_stale", 32'(seen), 32'd0);
    chk("rst_mul:in_ready_post", 32'(in_ready), 32'd1);
    run_op("add_post_rst", 4'd0, 8'd1, 8'd1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU with a valid/ready handshake. It succeeds the 8-bit combinational ALU and sits between operand fetch and writeback in the datapath. Single-cycle ops complete in one clock. Shifts iterate one bit per clock, and a new multiply op runs shift-and-add over WIDTH clocks. It adds a carry/borrow flag and a full-width multiply result.

## Interface
Parameters:
- WIDTH, 8, operand/result width (≥4)
- SHW, $clog2(WIDTH), shift-counter width (derived, not overridden)

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  operands/op presented.
- in_ready  out  1  block can accept; equals (state==IDLE).
- op  in  4  opcode, type alu_op_t from definitions.
- in_a, in_b  in  WIDTH  operands, unsigned.
- out_valid  out  1  result registers valid.
- out_ready  in  1  consumer takes result.
- rslt  out  WIDTH  result (low half for MUL).
- rslt_hi  out  WIDTH  MUL high half; 0 for all other ops.
- z  out  1  compare flag.
- c  out  1  carry (ADD) / borrow (SUB).

## Operation
- States: IDLE, SHIFT, MUL, DONE.
- Accept: in_valid && in_ready. op, in_a and in_b are captured into internal registers. Later input changes are ignored.
- Transitions out of IDLE on accept:
  - ADD, SUB, XOR, AND, BE, BNE, undefined op, and SL/SR with in_b==0 or in_b≥WIDTH go to DONE.
  - SL/SR with 0<in_b<WIDTH goes to SHIFT; the counter loads in_b.
  - MUL goes to MUL; the counter loads WIDTH.
- SHIFT: shift the working register one bit per clock (SL shifts left, SR shifts logical right) and decrement the counter. When the counter reaches 1, go to DONE.
- MUL: radix-2 shift-and-add into a 2·WIDTH accumulator, one multiplier bit per clock. After WIDTH clocks, go to DONE.
- DONE: out_valid=1. When out_ready is 1, go to IDLE. No new accept occurs in DONE.
- Results:
  - ADD: rslt=(a+b) mod 2^WIDTH, c=carry-out.
  - SUB: rslt=(a−b) mod 2^WIDTH, c=(a<b).
  - XOR, AND: bitwise; c=0.
  - SL/SR by ≥WIDTH: rslt=0.
  - BE: z=(a==b), rslt=0. BNE: z=(a!=b), rslt=0.
  - MUL: {rslt_hi,rslt}=a·b; c=0.
  - Undefined op: rslt=all ones, z=0, c=0.
  - z=0 for every op except BE/BNE.
- rslt, rslt_hi, z and c are registered. They are stable from entry into DONE until the handshake completes.
- Reset (any state, any time): state=IDLE; out_valid=0, rslt=0, rslt_hi=0, z=0, c=0; in_ready=1 (state is IDLE). An in-flight op is discarded and never produces an output.

## Timing
- Latency is counted from the accept edge to the first clock with out_valid=1:
  - single-cycle ops: 1
  - SL/SR by n (0<n<WIDTH): 1+n
  - MUL: WIDTH+1
- Throughput: at most one op in flight. The next accept is possible one clock after the out_ready handshake.
- Backpressure: out_valid stays high and the outputs are held for any number of clocks with out_ready=0.
- out_ready high outside DONE is ignored. in_valid outside IDLE is ignored; the producer must hold it.

## Structure
- The definitions package gains:
  - alu_op_t (4-bit enum): aluADD, aluSUB, aluSL, aluSR, aluXOR, aluAND, aluBE, aluBNE, aluMUL.
  - alu_state_t: IDLE, SHIFT, MUL, DONE.
- One sub-module, alu_mul_iter, holds the shift-and-add multiplier datapath: accumulator, multiplier shift register and bit counter, with start/done strobes. The FSM, shifter and single-cycle ops stay in alu_mc.

## Test plan
All cases use WIDTH=8.
- ADD 8'hF0+8'h20 → rslt=8'h10, c=1, z=0, out_valid one clock after accept. SUB 8'h03−8'h05 → rslt=8'hFE, c=1.
- SL 8'h01 by 3 → rslt=8'h08 with out_valid at accept+4. SR 8'h80 by 9 → rslt=8'h00 at accept+1. SL by 0 → rslt=in_a at accept+1.
- MUL 8'd13×8'd11 → rslt=8'h8F, rslt_hi=8'h00. MUL 8'hFF×8'hFF → rslt=8'h01, rslt_hi=8'hFE. Both have out_valid at accept+9.
- BE 5,5 → z=1, rslt=0. BNE 5,5 → z=0. BNE 5,6 → z=1. Opcode 4'hF → rslt=8'hFF, z=0.
- Backpressure: hold out_ready=0 for 3 clocks after ADD completes → outputs unchanged and in_ready=0. Then raise out_ready → in_ready=1 the next clock, and a second op is accepted.
- rst_n low during the 4th MUL clock → out_valid=0 and all outputs 0 immediately (asynchronous). After release in_ready=1 and no stale result appears. A following ADD 1+1 returns 2.
